// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the multi-channel UART receive arbiter.
//   BYTE_WIDTH_DEF : default receiver byte width
//   arb_state_t    : downstream port state (idle / presenting a byte)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_WIDTH_DEF = 8;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Selects the first requesting channel
// strictly after last_grant_i, wrapping modulo NUM_CH.
// Ports:
//   req_i        in  NUM_CH  per-channel request (holding register full)
//   last_grant_i in  CH_W    most recently granted channel
//   gnt_valid_o  out 1       at least one request is present
//   gnt_idx_o    out CH_W    picked channel (0 when gnt_valid_o=0)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   last_grant_i,
    output logic              gnt_valid_o,
    output logic [CH_W-1:0]   gnt_idx_o
);

    int idx;

    // Walk the distances from farthest to nearest so the nearest requester
    // after last_grant_i is the final assignment and therefore wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        idx         = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(last_grant_i) + k) % NUM_CH;
            if (req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_rx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_rx_arbiter
// Merges NUM_CH UART receiver byte strobes into one valid/ready byte stream
// tagged with the source channel. Each channel owns a one-entry holding
// register; a round-robin arbiter shares the output port. A byte arriving
// while the channel's holding register is still occupied (and not being
// popped that cycle) is dropped and reported on overrun_o.
// Optional build macro: UART_RX_ARB_STATUS_EN adds sticky overrun status
// bits (ovr_status_o) with per-channel clear (ovr_clr_i).
// Ports:
//   clk, arst_n    clock, asynchronous active-low reset
//   rx_done_i      per-channel byte-complete strobe
//   rx_data_i      per-channel byte, channel c at [c*BYTE_WIDTH +: BYTE_WIDTH]
//   m_valid/m_ready/m_data/m_ch  downstream byte stream with channel tag
//   ovr_clr_i      (optional) per-channel sticky status clear
//   ovr_status_o   (optional) per-channel sticky overrun status
//   overrun_o      one-cycle pulse per dropped byte
// ---------------------------------------------------------------------------
module uart_rx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [NUM_CH-1:0]            rx_done_i,
    input  logic [NUM_CH*BYTE_WIDTH-1:0] rx_data_i,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [BYTE_WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]              m_ch,
`ifdef UART_RX_ARB_STATUS_EN
    input  logic [NUM_CH-1:0]            ovr_clr_i,
    output logic [NUM_CH-1:0]            ovr_status_o,
`endif
    output logic [NUM_CH-1:0]            overrun_o
);

    arb_state_t            state_q, state_d;
    logic [NUM_CH-1:0]     full_q, full_d;
    logic [BYTE_WIDTH-1:0] hold_q [NUM_CH];
    logic [BYTE_WIDTH-1:0] hold_d [NUM_CH];
    logic [CH_W-1:0]       last_q, last_d;
    logic                  m_valid_q, m_valid_d;
    logic [BYTE_WIDTH-1:0] m_data_q, m_data_d;
    logic [CH_W-1:0]       m_ch_q, m_ch_d;
    logic [NUM_CH-1:0]     overrun_q, overrun_d;

    logic                  gnt_valid;
    logic [CH_W-1:0]       gnt_idx;
    logic                  pop;
    logic [NUM_CH-1:0]     popped;

    rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_rr_arbiter (
        .req_i       (full_q),
        .last_grant_i(last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // A new byte may be moved to the output when the port is idle, or when
    // the byte currently presented is accepted this cycle.
    assign pop    = gnt_valid &&
                    ((state_q == ARB_IDLE) || (state_q == ARB_SEND && m_valid_q && m_ready));
    assign popped = pop ? (NUM_CH'(1) << gnt_idx) : '0;

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ch_d    = m_ch_q;
        last_d    = last_q;

        case (state_q)
            ARB_IDLE: begin
                if (pop) state_d = ARB_SEND;
            end
            ARB_SEND: begin
                if (m_valid_q && m_ready && !pop) begin
                    state_d   = ARB_IDLE;
                    m_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                m_valid_d = 1'b0;
            end
        endcase

        if (pop) begin
            state_d   = ARB_SEND;
            m_valid_d = 1'b1;
            m_data_d  = hold_q[gnt_idx];
            m_ch_d    = gnt_idx;
            last_d    = gnt_idx;
        end
    end

    // Per-channel holding register. A channel being popped this cycle counts
    // as free, so a refill in the same cycle is accepted without overrun.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            full_d[c]    = full_q[c];
            hold_d[c]    = hold_q[c];
            overrun_d[c] = 1'b0;
            if (rx_done_i[c]) begin
                if (!full_q[c] || popped[c]) begin
                    full_d[c] = 1'b1;
                    hold_d[c] = rx_data_i[c*BYTE_WIDTH +: BYTE_WIDTH];
                end else begin
                    overrun_d[c] = 1'b1;
                end
            end else if (popped[c]) begin
                full_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ARB_IDLE;
            full_q    <= '0;
            last_q    <= CH_W'(NUM_CH - 1);
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            last_q    <= last_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ch_q    <= m_ch_d;
            overrun_q <= overrun_d;
        end
    end

    // Holding data is qualified by full_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            hold_q[c] <= hold_d[c];
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_ch      = m_ch_q;
    assign overrun_o = overrun_q;

`ifdef UART_RX_ARB_STATUS_EN
    logic [NUM_CH-1:0] ovr_status_q, ovr_status_d;

    // Set dominates clear so an overrun coinciding with a clear is not lost.
    assign ovr_status_d = (ovr_status_q & ~ovr_clr_i) | overrun_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) ovr_status_q <= '0;
        else         ovr_status_q <= ovr_status_d;
    end

    assign ovr_status_o = ovr_status_q;
`endif

endmodule

// File: tb/tb_uart_rx_arbiter.sv
module tb_uart_rx_arbiter;

    localparam int NCH = 4;
    localparam int BW  = 8;

    logic              clk = 1'b0;
    logic              arst_n;
    logic [NCH-1:0]    rx_done;
    logic [NCH*BW-1:0] rx_data;
    logic              m_valid;
    logic              m_ready;
    logic [BW-1:0]     m_data;
    logic [1:0]        m_ch;
    logic [NCH-1:0]    overrun;
`ifdef UART_RX_ARB_STATUS_EN
    logic [NCH-1:0]    ovr_clr;
    logic [NCH-1:0]    ovr_status;
`endif

    uart_rx_arbiter #(.NUM_CH(NCH), .BYTE_WIDTH(BW)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .rx_done_i   (rx_done),
        .rx_data_i   (rx_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_ch        (m_ch),
`ifdef UART_RX_ARB_STATUS_EN
        .ovr_clr_i   (ovr_clr),
        .ovr_status_o(ovr_status),
`endif
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending bytes per channel, the byte on the output port,
    // and the channel served most recently.
    bit            mfull [NCH];
    logic [BW-1:0] mhold [NCH];
    int            mlast;
    bit            mvalid;
    logic [BW-1:0] mdata;
    int            mch;
    logic [NCH-1:0] movr;
    logic [NCH-1:0] mstat;

    logic [BW-1:0] bdata [$];
    int            bch   [$];

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) mfull[c] = 1'b0;
        mlast  = NCH - 1;
        mvalid = 1'b0;
        mdata  = '0;
        mch    = 0;
        movr   = '0;
        mstat  = '0;
        bdata.delete();
        bch.delete();
    endfunction

    function automatic void model_edge();
        int pick = -1;
        bit take;
        for (int k = 1; k <= NCH; k++)
            if (pick < 0 && mfull[(mlast + k) % NCH]) pick = (mlast + k) % NCH;
        take = (pick >= 0) && (!mvalid || m_ready);
`ifdef UART_RX_ARB_STATUS_EN
        mstat = (mstat & ~ovr_clr) | movr;
`endif
        if (take) begin
            mdata  = mhold[pick];
            mch    = pick;
            mvalid = 1'b1;
            mlast  = pick;
        end else if (mvalid && m_ready) begin
            mvalid = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            bit freed = take && (pick == c);
            movr[c] = 1'b0;
            if (rx_done[c]) begin
                if (!mfull[c] || freed) begin
                    mfull[c] = 1'b1;
                    mhold[c] = rx_data[c*BW +: BW];
                end else begin
                    movr[c] = 1'b1;
                end
            end else if (freed) begin
                mfull[c] = 1'b0;
            end
        end
    endfunction

    task automatic step();
        if (m_valid && m_ready) begin
            bdata.push_back(m_data);
            bch.push_back(int'(m_ch));
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("m_valid", m_valid, mvalid);
        chk("m_data", m_data, mdata);
        chk("m_ch", m_ch, mch);
        chk("overrun_o", overrun, movr);
`ifdef UART_RX_ARB_STATUS_EN
        chk("ovr_status", ovr_status, mstat);
`endif
    endtask

    task automatic do_reset();
        rx_done = '0;
        rx_data = '0;
        m_ready = 1'b0;
`ifdef UART_RX_ARB_STATUS_EN
        ovr_clr = '0;
`endif
        arst_n  = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_ch", m_ch, 0);
        chk("rst_overrun", overrun, 0);
`ifdef UART_RX_ARB_STATUS_EN
        chk("rst_status", ovr_status, 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovc;

        // Single byte on channel 2: valid two cycles after the strobe.
        do_reset();
        m_ready = 1'b1;
        rx_done = 4'b0100;
        rx_data = 32'h00A5_0000;
        step();
        rx_done = '0;
        chk("single_t1_valid", m_valid, 0);
        step();
        chk("single_valid", m_valid, 1);
        chk("single_data", m_data, 8'hA5);
        chk("single_ch", m_ch, 2);
        step();
        chk("single_one_beat", m_valid, 0);

        // All four channels at once: beats 0,1,2,3 with no bubbles.
        do_reset();
        m_ready = 1'b1;
        rx_done = 4'b1111;
        rx_data = 32'h1312_1110;
        step();
        rx_done = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("simul_valid", m_valid, 1);
            chk("simul_ch", m_ch, i);
            chk("simul_data", m_data, 8'h10 + i);
        end
        step();
        chk("simul_end", m_valid, 0);

        // Back-pressure: first byte goes to the port, second waits in the
        // holding register, third is dropped.
        do_reset();
        m_ready = 1'b0;
        ovc = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            rx_done = (cyc == 0 || cyc == 2 || cyc == 4) ? 4'b0010 : 4'b0000;
            rx_data = (cyc == 0) ? 32'h0000_3300 : (cyc == 2) ? 32'h0000_4400 : 32'h0000_5500;
            step();
            if (overrun[1]) ovc++;
            if (cyc >= 1) chk("stall_data", m_data, 8'h33);
        end
        chk("stall_ovr_count", ovc, 1);
        rx_done = '0;
        m_ready = 1'b1;
        step();
        step();
        step();
        chk("stall_beats", bdata.size(), 2);
        if (bdata.size() == 2) begin
            chk("stall_beat0", bdata[0], 8'h33);
            chk("stall_beat1", bdata[1], 8'h44);
            chk("stall_ch1", bch[1], 1);
        end

        // Refill of channel 0 in the same cycle it is popped.
        do_reset();
        m_ready = 1'b1;
        rx_done = 4'b0001;
        rx_data = 32'h0000_0066;
        step();
        rx_data = 32'h0000_0077;
        step();
        rx_done = '0;
        chk("coll_no_ovr", overrun, 0);
        chk("coll_first", m_data, 8'h66);
        step();
        chk("coll_valid", m_valid, 1);
        chk("coll_data", m_data, 8'h77);
        chk("coll_ch", m_ch, 0);
        step();

        // Fairness under continuous refill, starting from last grant ch3.
        do_reset();
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            rx_done = 4'b1111;
            rx_data = $urandom;
            step();
        end
        rx_done = '0;
        chk("fair_count", bch.size() >= 5, 1);
        if (bch.size() >= 5) begin
            chk("fair_g0", bch[0], 0);
            chk("fair_g1", bch[1], 1);
            chk("fair_g2", bch[2], 2);
            chk("fair_g3", bch[3], 3);
            chk("fair_g4", bch[4], 0);
        end
        repeat (6) step();

        // Reset while a byte is presented.
        do_reset();
        m_ready = 1'b0;
        rx_done = 4'b1111;
        rx_data = 32'hDDCC_BBAA;
        step();
        rx_done = '0;
        step();
        chk("midrst_pre_valid", m_valid, 1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("midrst_valid", m_valid, 0);
        chk("midrst_data", m_data, 0);
        chk("midrst_ch", m_ch, 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        model_reset();
        m_ready = 1'b1;
        repeat (6) step();
        chk("midrst_no_beats", bch.size(), 0);

`ifdef UART_RX_ARB_STATUS_EN
        // Sticky status: set by overrun, held, set beats clear, then cleared.
        do_reset();
        m_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            rx_done = (cyc == 0 || cyc == 2 || cyc == 4) ? 4'b0100 : 4'b0000;
            rx_data = 32'h0042_0000;
            step();
        end
        chk("stat_set", ovr_status[2], 1);
        chk("stat_others", ovr_status & 4'b1011, 0);
        rx_done = 4'b0100;
        step();
        rx_done = '0;
        chk("stat_ovr_pulse", overrun[2], 1);
        ovr_clr = 4'b0100;
        step();
        chk("stat_set_wins", ovr_status[2], 1);
        step();
        ovr_clr = '0;
        chk("stat_cleared", ovr_status[2], 0);
        step();
        chk("stat_stays_clear", ovr_status[2], 0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NCH; c++) rx_done[c] = ($urandom_range(0, 3) == 0);
            rx_data = $urandom;
            m_ready = ($urandom_range(0, 2) != 0);
`ifdef UART_RX_ARB_STATUS_EN
            for (int c = 0; c < NCH; c++) ovr_clr[c] = ($urandom_range(0, 9) == 0);
`endif
            step();
        end
        rx_done = '0;
        m_ready = 1'b1;
        repeat (10) step();
        chk("drain_idle", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
